alu_operand_sequencer: RTL and testbench

Sequencer between the board input bus (switches plus a debounced load strobe) and the combinational 8-bit ALU/adder. It captures operand A, operand B and the opcode, in that order, from one shared data bus. It presents them to the ALU and registers the ALU result with carry and zero flags. It also rejects unsupported opcodes and reports its state for LED display.

---
 rtl/alu_operand_sequencer.sv | 118 +++++++++++
 tb/tb_alu_operand_sequencer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_sequencer.sv
// Operand/opcode sequencer in front of a combinational ALU: captures A, B, op
// from one shared switch bus, runs one EXEC cycle and registers result + flags.
module alu_operand_sequencer #(
    parameter int DATA_W = 8,
    parameter int OP_W   = 6
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_load,
    input  logic              i_clear,
    output logic [DATA_W-1:0] o_alu_a,
    output logic [DATA_W-1:0] o_alu_b,
    output logic [OP_W-1:0]   o_alu_op,
    input  logic [DATA_W-1:0] i_alu_result,
    input  logic              i_alu_carry,
    output logic [DATA_W-1:0] o_result,
    output logic              o_carry,
    output logic              o_zero,
    output logic              o_valid,
    output logic              o_busy,
    output logic              o_err,
    output logic [2:0]        o_state
);

    typedef enum logic [2:0] {
        S_WAIT_A  = 3'd0,
        S_WAIT_B  = 3'd1,
        S_WAIT_OP = 3'd2,
        S_EXEC    = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t            state_q;
    logic [DATA_W-1:0] a_q, b_q, result_q;
    logic [OP_W-1:0]   op_q, op_d;
    logic              carry_q, zero_q, valid_q, err_q;
    logic              op_ok_d;

    function automatic logic opcode_valid(input logic [OP_W-1:0] op);
        case (op)
            OP_W'(6'b100000), OP_W'(6'b100010), OP_W'(6'b100100),
            OP_W'(6'b100101), OP_W'(6'b100110), OP_W'(6'b100111),
            OP_W'(6'b000011), OP_W'(6'b000010): opcode_valid = 1'b1;
            default:                            opcode_valid = 1'b0;
        endcase
    endfunction

    always_comb begin
        op_d    = i_data[OP_W-1:0];
        op_ok_d = opcode_valid(op_d);
    end

    // Clear has priority over any load; result flags survive a clear.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= S_WAIT_A;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else if (i_clear) begin
            state_q <= S_WAIT_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                S_WAIT_A: if (i_load) begin
                    a_q     <= i_data;
                    err_q   <= 1'b0;
                    state_q <= S_WAIT_B;
                end
                S_WAIT_B: if (i_load) begin
                    b_q     <= i_data;
                    state_q <= S_WAIT_OP;
                end
                S_WAIT_OP: if (i_load) begin
                    if (op_ok_d) begin
                        op_q    <= op_d;
                        state_q <= S_EXEC;
                    end else begin
                        err_q   <= 1'b1;
                        state_q <= S_WAIT_A;
                    end
                end
                S_EXEC: begin
                    result_q <= i_alu_result;
                    carry_q  <= i_alu_carry;
                    zero_q   <= (i_alu_result == '0);
                    valid_q  <= 1'b1;
                    state_q  <= S_DONE;
                end
                S_DONE:  state_q <= S_WAIT_A;
                default: state_q <= S_WAIT_A;
            endcase
        end
    end

    assign o_alu_a  = a_q;
    assign o_alu_b  = b_q;
    assign o_alu_op = op_q;
    assign o_result = result_q;
    assign o_carry  = carry_q;
    assign o_zero   = zero_q;
    assign o_valid  = valid_q;
    assign o_err    = err_q;
    assign o_busy   = (state_q == S_EXEC) || (state_q == S_DONE);
    assign o_state  = state_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Transaction-level bench: random and directed A/B/op entries checked against
// expected values computed with plain arithmetic.
module tb_alu_operand_sequencer;
    logic       i_clk = 1'b0;
    logic       i_reset = 1'b1;
    logic [7:0] i_data = '0;
    logic       i_load = 1'b0;
    logic       i_clear = 1'b0;
    logic [7:0] o_alu_a, o_alu_b, o_result, i_alu_result;
    logic [5:0] o_alu_op;
    logic       i_alu_carry, o_carry, o_zero, o_valid, o_busy, o_err;
    logic [2:0] o_state;

    int n_chk = 0;
    int n_fail = 0;

    // expected architectural view
    int m_a = 0, m_b = 0, m_op = 0, m_res = 0, m_carry = 0, m_zero = 0, m_err = 0;

    alu_operand_sequencer #(.DATA_W(8), .OP_W(6)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_data(i_data), .i_load(i_load),
        .i_clear(i_clear), .o_alu_a(o_alu_a), .o_alu_b(o_alu_b),
        .o_alu_op(o_alu_op), .i_alu_result(i_alu_result),
        .i_alu_carry(i_alu_carry), .o_result(o_result), .o_carry(o_carry),
        .o_zero(o_zero), .o_valid(o_valid), .o_busy(o_busy), .o_err(o_err),
        .o_state(o_state)
    );

    always #5 i_clk = ~i_clk;

    // Environment ALU, bit-level
    always_comb begin
        logic [8:0] t;
        t = 9'd0;
        case (o_alu_op)
            6'b100000: t = {1'b0, o_alu_a} + {1'b0, o_alu_b};
            6'b100010: t = {1'b0, o_alu_a} - {1'b0, o_alu_b};
            6'b100100: t = {1'b0, o_alu_a & o_alu_b};
            6'b100101: t = {1'b0, o_alu_a | o_alu_b};
            6'b100110: t = {1'b0, o_alu_a ^ o_alu_b};
            6'b100111: t = {1'b0, ~(o_alu_a | o_alu_b)};
            6'b000011: t = {1'b0, 8'($signed(o_alu_a) >>> o_alu_b[2:0])};
            6'b000010: t = {1'b0, o_alu_a >> o_alu_b[2:0]};
            default:   t = 9'd0;
        endcase
        i_alu_result = t[7:0];
        i_alu_carry  = t[8];
    end

    function automatic bit is_valid_op(input int op);
        return op == 32 || op == 34 || op == 36 || op == 37 ||
               op == 38 || op == 39 || op == 3 || op == 2;
    endfunction

    // Integer-arithmetic reference of what the ALU should produce
    function automatic void ref_alu(input int a, input int b, input int op,
                                    output int res, output int cy);
        int sh;
        sh = b % 8;
        cy = 0;
        case (op)
            32: begin res = (a + b) % 256; cy = (a + b > 255); end
            34: begin res = (a - b + 256) % 256; cy = (a < b); end
            36: res = a & b;
            37: res = a | b;
            38: res = a ^ b;
            39: res = 255 - (a | b);
            3:  res = ((a >= 128 ? a - 256 : a) >>> sh) & 255;
            2:  res = a / (1 << sh);
            default: res = 0;
        endcase
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input bit ld, input bit clr, input logic [7:0] d);
        i_load = ld; i_clear = clr; i_data = d;
        @(posedge i_clk); #1;
        i_load = 1'b0; i_clear = 1'b0;
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, ".a"}, int'(o_alu_a), m_a);
        chk({tag, ".b"}, int'(o_alu_b), m_b);
        chk({tag, ".op"}, int'(o_alu_op), m_op);
        chk({tag, ".res"}, int'(o_result), m_res);
        chk({tag, ".cy"}, int'(o_carry), m_carry);
        chk({tag, ".z"}, int'(o_zero), m_zero);
        chk({tag, ".err"}, int'(o_err), m_err);
    endtask

    task automatic model_reset();
        m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_carry = 0; m_zero = 0; m_err = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".state"}, int'(o_state), 0);
        chk({tag, ".valid"}, int'(o_valid), 0);
        chk({tag, ".busy"}, int'(o_busy), 0);
        chk_regs(tag);
    endtask

    task automatic load_ab(input int a, input int b);
        cyc(1, 0, 8'(a)); m_a = a; m_err = 0;
        chk("A.state", int'(o_state), 1);
        chk_regs("A");
        cyc(1, 0, 8'(b)); m_b = b;
        chk("B.state", int'(o_state), 2);
        chk_regs("B");
    endtask

    // Full entry; busy_ld drives 0xAA loads while EXEC/DONE.
    task automatic txn(input int a, input int b, input int op, input bit busy_ld);
        int r, c;
        logic [1:0] hi;
        load_ab(a, b);
        hi = 2'($urandom);
        cyc(1, 0, {hi, 6'(op)});
        if (is_valid_op(op)) begin
            m_op = op;
            chk("OP.state", int'(o_state), 3);
            chk("OP.busy", int'(o_busy), 1);
            chk("OP.valid", int'(o_valid), 0);
            chk_regs("OP");
            cyc(busy_ld, 0, 8'hAA);
            ref_alu(a, b, op, r, c);
            m_res = r; m_carry = c; m_zero = (r == 0);
            chk("EX.state", int'(o_state), 4);
            chk("EX.valid", int'(o_valid), 1);
            chk_regs("EX");
            cyc(busy_ld, 0, 8'hAA);
            chk("DN.state", int'(o_state), 0);
            chk("DN.valid", int'(o_valid), 0);
            chk("DN.busy", int'(o_busy), 0);
            chk_regs("DN");
        end else begin
            m_err = 1;
            chk("BAD.state", int'(o_state), 0);
            chk("BAD.valid", int'(o_valid), 0);
            chk_regs("BAD");
            cyc(0, 0, 8'h00);
            chk("BAD2.valid", int'(o_valid), 0);
        end
    endtask

    initial begin
        int a, b, op, gap;
        #2;
        chk_all_zero("RST");
        #10 i_reset = 1'b0;
        @(posedge i_clk); #1;
        chk_all_zero("RST2");

        // directed plan
        txn(255, 1, 32, 0);
        chk("add.res", int'(o_result), 0);
        chk("add.cy", int'(o_carry), 1);
        txn(5, 3, 34, 0);
        chk("sub.res", int'(o_result), 2);
        txn(3, 3, 34, 0);
        chk("sub0.z", int'(o_zero), 1);
        txn(7, 9, 63, 0);
        chk("inv.res", int'(o_result), 0);
        load_ab(12, 4);
        chk("inv.errclr", int'(o_err), 0);
        cyc(1, 0, 8'h24); m_op = 36;
        cyc(0, 0, 8'h00); m_res = 4; m_carry = 0; m_zero = 0;
        chk_regs("and");
        cyc(0, 0, 8'h00);
        txn(17, 40, 37, 1);
        chk("busy.a", int'(o_alu_a), 17);

        // clear collides with op load
        load_ab(100, 50);
        cyc(1, 1, 8'h20); m_a = 0; m_b = 0; m_op = 0; m_err = 0;
        chk("clr.state", int'(o_state), 0);
        chk("clr.valid", int'(o_valid), 0);
        chk_regs("clr");
        cyc(0, 0, 8'h00);
        chk("clr2.state", int'(o_state), 0);

        // async reset while in EXEC
        load_ab(9, 9);
        cyc(1, 0, 8'h20);
        chk("pre.state", int'(o_state), 3);
        #2 i_reset = 1'b1;
        #1; model_reset();
        chk_all_zero("ARST");
        #2 i_reset = 1'b0;
        @(posedge i_clk); #1;
        chk_all_zero("ARST2");
        txn(1, 2, 32, 0);
        chk("post.res", int'(o_result), 3);

        // random traffic
        for (int i = 0; i < 60; i++) begin
            a = int'($urandom_range(0, 255));
            b = int'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) begin
                case ($urandom_range(0, 7))
                    0: op = 32; 1: op = 34; 2: op = 36; 3: op = 37;
                    4: op = 38; 5: op = 39; 6: op = 3; default: op = 2;
                endcase
            end else begin
                op = int'($urandom_range(0, 63));
                while (is_valid_op(op)) op = int'($urandom_range(0, 63));
            end
            if ($urandom_range(0, 9) == 0) begin
                cyc(1, 0, 8'(a)); m_a = a; m_err = 0;
                cyc(0, 1, 8'h00); m_a = 0; m_b = 0; m_op = 0;
                chk("rclr.state", int'(o_state), 0);
                chk_regs("rclr");
            end else begin
                txn(a, b, op, 1'($urandom));
            end
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                cyc(0, 0, 8'($urandom));
                chk("gap.state", int'(o_state), 0);
                chk("gap.valid", int'(o_valid), 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
